alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present on a/b/alu_ctrl.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 a  input  32  signed operand A.
REQ-007 b  input  32  signed operand B.
REQ-008 alu_ctrl  input  4  operation code.
REQ-009 rsp_valid  output  1  response held on result outputs.
REQ-010 rsp_ready  input  1  consumer takes response.
REQ-011 res  output  32  result (low word for MULT).
REQ-012 res_hi  output  32  MULT high word; 0 for all other ops.
REQ-013 zero  output  1  result equals zero (64-bit {res_hi,res} for MULT).
REQ-014 carry_out  output  1  carry of the 33-bit add (ADD/SUB only).
REQ-015 overflow  output  1  signed overflow (ADD/SUB only).
REQ-016 illegal  output  1  request carried an undefined alu_ctrl.

Function
REQ-017 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 XNOR, 1000 MULT (signed 32x32->64); all others illegal.
REQ-018 FSM states IDLE, MUL, RESP; req_ready = 1 only in IDLE.
REQ-019 Request accepted on an edge with req_valid && req_ready; a, b, alu_ctrl captured at that edge.
REQ-020 Non-MULT accept: IDLE->RESP; result registered at the accept edge; rsp_valid = 1 in the next cycle (latency 1).
REQ-021 MULT accept: IDLE->MUL; iterative shift-add on operand magnitudes, one step per cycle, 32 steps; sign applied at the end; MUL->RESP; rsp_valid = 1 exactly 33 cycles after the accept edge.
REQ-022 MULT is exact over the full range, including 0x80000000 * 0x80000000 = 0x4000000000000000.
REQ-023 ADD: res = a+b mod 2^32; carry_out = bit 32 of the unsigned sum; overflow = operand signs equal and result sign differs.
REQ-024 SUB: computed as a + ~b + 1; carry_out = bit 32 of that sum; overflow = operand signs differ and result sign differs from a.
REQ-025 SLT: res = 1 if a < b signed, else 0; correct even when a-b overflows; overflow = 0, carry_out = 0.
REQ-026 AND/OR/XNOR/MULT/illegal: overflow = 0, carry_out = 0.
REQ-027 Illegal opcode: res = 0, res_hi = 0, zero = 0, illegal = 1; latency 1 (same path as REQ-020).
REQ-028 RESP: all result outputs held stable while rsp_valid && !rsp_ready; on rsp_ready the state goes to IDLE at that edge.
REQ-029 Back-to-back accepts are not allowed: after a response handshake, req_ready = 1 in the following cycle; maximum throughput is 1 request per 2 cycles.
REQ-030 req_valid is ignored in MUL and RESP; no request is queued or lost-state corrupted.
REQ-031 Result outputs are don't-care-free: when rsp_valid = 0 they hold the last response (0 after reset).

Reset
REQ-032 At an edge with rst = 1: state IDLE; rsp_valid, res, res_hi, zero, carry_out, overflow, illegal all 0; MUL step counter cleared.
REQ-033 req_ready = 0 while rst = 1; req_ready = 1 in the first cycle after rst deasserts.
REQ-034 Reset during MUL or RESP discards the operation; no response is produced for it.

Verification
REQ-035 ADD 0x7FFFFFFF + 1 -> res 0x80000000, overflow 1, carry_out 0, zero 0; rsp_valid 1 cycle after accept.
REQ-036 SUB 0x80000000 - 1 -> res 0x7FFFFFFF, overflow 1, carry_out 1; SUB -50 - (-50) -> res 0, zero 1.
REQ-037 SLT (-10,20) -> 1; (12,10) -> 0 with zero 1; (-12,-14) -> 0; (0x80000000,1) -> 1.
REQ-038 MULT -7*6 -> res_hi 0xFFFFFFFF, res 0xFFFFFFD6, rsp_valid exactly 33 cycles after accept; MULT 0x80000000*0x80000000 -> res_hi 0x40000000, res 0.
REQ-039 Backpressure: hold rsp_ready = 0 for 5 cycles with req_valid = 1 and new operands -> outputs unchanged, req_ready 0, no new accept; release -> IDLE next cycle.
REQ-040 rst asserted 10 cycles into MULT -> next cycle rsp_valid 0, req_ready 1 after deassert; then ADD 3+4 -> res 7; alu_ctrl 1111 -> illegal 1, res 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Request/response ALU: single-cycle logic/arithmetic ops plus a 32-step iterative
// signed multiplier. Results are registered and held until the consumer takes them.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XNOR = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0]   plier_q, plier_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic               accept;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic               slt_bit;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_ill;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // With differing signs the difference may overflow, but the answer is then a's sign.
    assign slt_bit = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sub_sum[WIDTH-1];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XNOR: alu_res = ~(a ^ b);
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: alu_ill = 1'b1;
        endcase
    end

    // Magnitudes as unsigned: the most negative value maps to 2^(WIDTH-1) exactly.
    assign a_mag    = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag    = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign acc_step = acc_q + (plier_q[0] ? cand_q : '0);
    assign prod     = neg_q ? (~acc_step + 1'b1) : acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        cand_d   = cand_q;
        plier_d  = plier_q;
        neg_d    = neg_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (alu_ctrl == OP_MULT) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        cand_d  = {{WIDTH{1'b0}}, a_mag};
                        plier_d = b_mag;
                        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        state_d  = RESP;
                        res_d    = alu_res;
                        res_hi_d = '0;
                        zero_d   = !alu_ill && (alu_res == '0);
                        carry_d  = alu_c;
                        ovf_d    = alu_v;
                        ill_d    = alu_ill;
                    end
                end
            end
            MUL: begin
                acc_d   = acc_step;
                cand_d  = cand_q << 1;
                plier_d = plier_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = RESP;
                    res_d    = prod[WIDTH-1:0];
                    res_hi_d = prod[2*WIDTH-1:WIDTH];
                    zero_d   = (prod == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            cand_q   <= '0;
            plier_q  <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            cand_q   <= cand_d;
            plier_q  <= plier_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule
